// File: rtl/memory_ram_512x32.sv
// -----------------------------------------------------------------------------
// memory_ram_512x32
//   Single-port synchronous 512 x 32 data RAM used as the processor's main
//   memory, sitting behind the MAR/MDR. Writes and reads both complete on the
//   rising edge of clk. data_output is registered and holds the last word read.
//
// Ports
//   clk          in   1          system clock, rising-edge active
//   clr          in   1          synchronous reset, active-low
//   read         in   1          read strobe, active-high
//   write        in   1          write strobe, active-high
//   address_in   in   ADDR_WIDTH word address
//   data_input   in   DATA_WIDTH write data
//   data_output  out  DATA_WIDTH registered read data
//
// Configuration macro
//   MEMORY_RAM_WRITE_THROUGH_EN
//     defined     : read+write to the same cycle returns the new data (write-first)
//     not defined : read+write returns the previous contents (read-first)
//
// The array has no reset: clr only clears data_output and blocks writes.
// -----------------------------------------------------------------------------
module memory_ram_512x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] data_input,
  output logic [DATA_WIDTH-1:0] data_output
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_output_q;
  logic [DATA_WIDTH-1:0] data_output_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we_d;

  always_comb begin
    // A write during reset is dropped so clr leaves the array untouched.
    mem_we_d      = clr & write;
    rd_word       = mem_q[address_in];
    data_output_d = data_output_q;
    if (read) begin
`ifdef MEMORY_RAM_WRITE_THROUGH_EN
      data_output_d = write ? data_input : rd_word;
`else
      data_output_d = rd_word;
`endif
    end
  end

  // Kept free of reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[address_in] <= data_input;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      data_output_q <= '0;
    end else begin
      data_output_q <= data_output_d;
    end
  end

  assign data_output = data_output_q;

endmodule

// File: tb/tb_memory_ram_512x32.sv
module tb_memory_ram_512x32;

  logic        clk;
  logic        clr;
  logic        read;
  logic        write;
  logic [8:0]  address_in;
  logic [31:0] data_input;
  logic [31:0] data_output;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mem_m [512];

`ifdef MEMORY_RAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  memory_ram_512x32 dut (
    .clk        (clk),
    .clr        (clr),
    .read       (read),
    .write      (write),
    .address_in (address_in),
    .data_input (data_input),
    .data_output(data_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle. When chk is set the expected data_output after this edge
  // is pushed to the scoreboard and compared once the edge has happened.
  task automatic cycle(input bit c, input bit r, input bit w,
                       input logic [8:0] a, input logic [31:0] d,
                       input bit chk, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    string       n;
    @(negedge clk);
    clr        = c;
    read       = r;
    write      = w;
    address_in = a;
    data_input = d;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    if (c && w) mem_m[a] = d;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (data_output !== e) begin
        errors++;
        $display("FAIL %s: data_output=%h expected=%h", n, data_output, e);
      end
    end
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 32'h0, "");
  endtask

  task automatic test_clear();
    for (int i = 0; i < 512; i++)
      cycle(1'b1, 1'b0, 1'b1, 9'(i), 32'h0, 1'b0, 32'h0, "");
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b1, 9'd20, 32'h1234, 1'b0, 32'h0, "");
    cycle(1'b1, 1'b1, 1'b0, 9'd20, 32'h0, 1'b1, 32'h1234, "reset_preload");
    cycle(1'b0, 1'b0, 1'b0, 9'd20, 32'h0, 1'b1, 32'h0, "reset_clears_output");
    cycle(1'b1, 1'b1, 1'b0, 9'd20, 32'h0, 1'b1, 32'h1234, "reset_keeps_mem");
    // Reset while reading must still clear the output.
    cycle(1'b0, 1'b1, 1'b0, 9'd20, 32'h0, 1'b1, 32'h0, "reset_overrides_read");
  endtask

  task automatic test_write_read();
    cycle(1'b1, 1'b0, 1'b1, 9'd5, 32'h45, 1'b0, 32'h0, "");
    cycle(1'b1, 1'b0, 1'b1, 9'd10, 32'd420, 1'b1, 32'h0, "write_no_output_change");
    cycle(1'b1, 1'b1, 1'b0, 9'd5, 32'h0, 1'b1, 32'h45, "read_addr5");
  endtask

  task automatic test_hold();
    cycle(1'b1, 1'b1, 1'b0, 9'd10, 32'h0, 1'b1, 32'h1A4, "read_addr10");
    cycle(1'b1, 1'b0, 1'b0, 9'd5, 32'h0, 1'b1, 32'h1A4, "hold_after_read_drop");
    cycle(1'b1, 1'b0, 1'b1, 9'd12, 32'h777, 1'b1, 32'h1A4, "hold_during_write");
  endtask

  task automatic test_boundaries();
    cycle(1'b1, 1'b0, 1'b1, 9'd0, 32'hDEADBEEF, 1'b0, 32'h0, "");
    cycle(1'b1, 1'b0, 1'b1, 9'd511, 32'hCAFEF00D, 1'b0, 32'h0, "");
    cycle(1'b1, 1'b1, 1'b0, 9'd0, 32'h0, 1'b1, 32'hDEADBEEF, "read_addr0");
    cycle(1'b1, 1'b1, 1'b0, 9'd511, 32'h0, 1'b1, 32'hCAFEF00D, "read_addr511");
    cycle(1'b1, 1'b1, 1'b0, 9'd1, 32'h0, 1'b1, 32'h0, "read_addr1_zero");
    cycle(1'b1, 1'b1, 1'b0, 9'd510, 32'h0, 1'b1, 32'h0, "read_addr510_zero");
  endtask

  task automatic test_rw_collision();
    cycle(1'b1, 1'b0, 1'b1, 9'd7, 32'h11, 1'b0, 32'h0, "");
    cycle(1'b1, 1'b1, 1'b1, 9'd7, 32'h22, 1'b1, WT ? 32'h22 : 32'h11, "read_write_same_cycle");
    cycle(1'b1, 1'b1, 1'b0, 9'd7, 32'h0, 1'b1, 32'h22, "read_after_rw");
  endtask

  task automatic test_reset_write();
    cycle(1'b1, 1'b1, 1'b0, 9'd10, 32'h0, 1'b1, 32'h1A4, "pre_reset_read");
    cycle(1'b0, 1'b0, 1'b1, 9'd3, 32'h99, 1'b1, 32'h0, "reset_with_write");
    cycle(1'b1, 1'b1, 1'b0, 9'd3, 32'h0, 1'b1, 32'h0, "write_blocked_by_reset");
  endtask

  // Random back-to-back traffic on a small window, checked against mem_m.
  task automatic test_back_to_back();
    logic [31:0] dout_m;
    logic [8:0]  a;
    logic [31:0] d;
    bit          r, w;
    dout_m = 32'h0;
    cycle(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b1, 32'h0, "b2b_reset");
    for (int i = 0; i < 60; i++) begin
      a = 9'(504 + $urandom_range(0, 7));
      d = $urandom();
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (r) dout_m = (w && WT) ? d : mem_m[a];
      cycle(1'b1, r, w, a, d, 1'b1, dout_m, "b2b_random");
    end
  endtask

  initial begin
    clr        = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address_in = '0;
    data_input = '0;
    for (int i = 0; i < 512; i++) mem_m[i] = 32'h0;
    test_clear();
    test_reset();
    test_write_read();
    test_hold();
    test_boundaries();
    test_rw_collision();
    test_reset_write();
    test_back_to_back();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
